// File: rtl/brick_pkg.sv
// Shared types and constants for the brick-breaker scoring block:
// direction encoding, probe FSM states and per-row starting hit points.
package brick_pkg;

    localparam logic [1:0] DIR_UP_RIGHT   = 2'b00;
    localparam logic [1:0] DIR_UP_LEFT    = 2'b01;
    localparam logic [1:0] DIR_DOWN_RIGHT = 2'b10;
    localparam logic [1:0] DIR_DOWN_LEFT  = 2'b11;

    localparam int HP_W = 2;
    localparam logic [HP_W-1:0] HP_TOUGH  = 2'd2;
    localparam logic [HP_W-1:0] HP_NORMAL = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P0,
        ST_P1,
        ST_P2,
        ST_APPLY
    } state_t;

    function automatic logic [HP_W-1:0] init_hp(input int row, input int tough_rows);
        return (row < tough_rows) ? HP_TOUGH : HP_NORMAL;
    endfunction

    function automatic logic dir_is_down(input logic [1:0] dir);
        return dir[1];
    endfunction

    function automatic logic dir_is_left(input logic [1:0] dir);
        return dir[0];
    endfunction

endpackage

// File: rtl/brick_probe_addr.sv
// Maps a latched ball position, direction and probe number (0 own cell,
// 1 vertical neighbour, 2 horizontal neighbour) to a brick index and range flag.
module brick_probe_addr
    import brick_pkg::*;
#(
    parameter int ROWS    = 7,
    parameter int COLS    = 16,
    parameter int BRICK_W = 2,
    parameter int ROW_W   = 4,
    parameter int COL_W   = 4,
    localparam int BPR    = COLS / BRICK_W,
    localparam int IDX_W  = $clog2(ROWS * BPR)
) (
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    input  logic [1:0]       dir,
    input  logic [1:0]       probe,
    output logic [IDX_W-1:0] idx,
    output logic             in_range
);

    int cand_row;
    int cand_col;
    int own_col;
    int offset;
    logic exists;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        own_col  = int'(col) / BRICK_W;
        offset   = int'(col) % BRICK_W;
        cand_row = int'(row);
        cand_col = own_col;
        exists   = 1'b1;
        case (probe)
            2'd0: ;
            2'd1: cand_row = dir_is_down(dir) ? cand_row + 1 : cand_row - 1;
            2'd2: begin
                // Sideways probe only exists when the ball sits on the brick edge it moves toward.
                if (dir_is_left(dir) && offset == 0)
                    cand_col = own_col - 1;
                else if (!dir_is_left(dir) && offset == BRICK_W - 1)
                    cand_col = own_col + 1;
                else
                    exists = 1'b0;
            end
            default: exists = 1'b0;
        endcase

        in_range = exists && (cand_row >= 0) && (cand_row < ROWS)
                          && (cand_col >= 0) && (cand_col < BPR);
        idx      = in_range ? IDX_W'(cand_row * BPR + cand_col) : '0;
    end

endmodule

// File: rtl/brick_field_scorer.sv
// Brick field with per-brick hit points, a three-probe hit FSM, combo
// multiplier and saturating score for the brick-breaker game.
module brick_field_scorer
    import brick_pkg::*;
#(
    parameter int ROWS        = 7,
    parameter int COLS        = 16,
    parameter int BRICK_W     = 2,
    parameter int TOUGH_ROWS  = 2,
    parameter int BASE_POINTS = 1,
    parameter int COMBO_MAX   = 7,
    parameter int SCORE_W     = 10,
    parameter int ROW_W       = 4,
    parameter int COL_W       = 4,
    localparam int BPR        = COLS / BRICK_W,
    localparam int NB         = ROWS * BPR,
    localparam int COMBO_W    = $clog2(COMBO_MAX + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hit_valid,
    output logic               hit_ready,
    input  logic [ROW_W-1:0]   ball_row,
    input  logic [COL_W-1:0]   ball_col,
    input  logic [1:0]         ball_dir,
    input  logic               paddle_touch,
    input  logic               load_level,
    output logic               hit_done,
    output logic               hit_brick,
    output logic               destroyed,
    output logic [NB-1:0]      bricks,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic               level_clear
);

    localparam int IDX_W = $clog2(NB);
    localparam int PTS_W = SCORE_W + 4;
    localparam logic [PTS_W-1:0] SCORE_MAX = PTS_W'({SCORE_W{1'b1}});

    state_t state, state_nx;

    logic [ROW_W-1:0] req_row;
    logic [COL_W-1:0] req_col;
    logic [1:0]       req_dir;
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [HP_W-1:0]  hp [NB];

    logic [1:0]         probe_sel;
    logic [IDX_W-1:0]   probe_idx;
    logic               probe_in_range;
    logic               probe_live;
    logic               probing;
    logic               accept;
    logic [PTS_W-1:0]   points;
    logic [PTS_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_nx;
    logic [COMBO_W-1:0] combo_inc;

    brick_probe_addr #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .BRICK_W (BRICK_W),
        .ROW_W   (ROW_W),
        .COL_W   (COL_W)
    ) u_probe (
        .row      (req_row),
        .col      (req_col),
        .dir      (req_dir),
        .probe    (probe_sel),
        .idx      (probe_idx),
        .in_range (probe_in_range)
    );

    always_comb begin
        probe_sel = 2'd0;
        probing   = 1'b0;
        case (state)
            ST_P0:   begin probe_sel = 2'd0; probing = 1'b1; end
            ST_P1:   begin probe_sel = 2'd1; probing = 1'b1; end
            ST_P2:   begin probe_sel = 2'd2; probing = 1'b1; end
            default: ;
        endcase
    end

    // A cleared level holds only dead bricks, but gating keeps the miss explicit.
    assign probe_live = probe_in_range && (hp[probe_idx] != '0) && !level_clear;

    always_comb begin
        for (int i = 0; i < NB; i++)
            bricks[i] = (hp[i] != '0);
    end

    assign hit_ready = (state == ST_IDLE);
    assign hit_done  = (state == ST_APPLY);
    assign hit_brick = hit_done && found;
    assign destroyed = hit_brick && (hp[win_idx] == HP_W'(1));
    assign accept    = hit_valid && hit_ready;

    always_comb begin
        points    = PTS_W'(BASE_POINTS) * (PTS_W'(combo) + PTS_W'(1));
        score_sum = PTS_W'(score) + points;
        score_nx  = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
        combo_inc = (combo == COMBO_W'(COMBO_MAX)) ? combo : combo + COMBO_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (hit_valid) state_nx = ST_P0;
            ST_P0:    state_nx = ST_P1;
            ST_P1:    state_nx = ST_P2;
            ST_P2:    state_nx = ST_APPLY;
            ST_APPLY: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (load_level)
            state_nx = ST_IDLE;
    end

    // NOTE: the HP field is reset like any other register because reset defines the starting level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NB; i++)
                hp[i] <= init_hp(i / BPR, TOUGH_ROWS);
            score       <= '0;
            combo       <= '0;
            level_clear <= 1'b0;
            found       <= 1'b0;
            win_idx     <= '0;
            req_row     <= '0;
            req_col     <= '0;
            req_dir     <= '0;
        end else if (load_level) begin
            for (int i = 0; i < NB; i++)
                hp[i] <= init_hp(i / BPR, TOUGH_ROWS);
            combo       <= '0;
            level_clear <= 1'b0;
            found       <= 1'b0;
        end else begin
            level_clear <= level_clear | ~(|bricks);

            if (accept) begin
                req_row <= ball_row;
                req_col <= ball_col;
                req_dir <= ball_dir;
                found   <= 1'b0;
            end

            if (probing && !found && probe_live) begin
                found   <= 1'b1;
                win_idx <= probe_idx;
            end

            if (hit_brick) begin
                hp[win_idx] <= hp[win_idx] - HP_W'(1);
                if (destroyed) begin
                    score <= score_nx;
                    combo <= combo_inc;
                end
            end

            // Points above already used the pre-clear combo.
            if (paddle_touch)
                combo <= '0;
        end
    end

endmodule

// File: doc/brick_field_scorer.md
Name: brick_field_scorer

Overview:
- Parametrised successor to the fixed 7x8 brick/score block for the brick-breaker game.
- Holds a ROWS x BRICKS_PER_ROW brick field with per-brick hit points and takes ball-position hit requests over a valid/ready handshake.
- Probes up to three candidate bricks per request, with no wrap across rows, then updates the field, a combo multiplier and a saturating score.
- Sits between the ball controller and the display/score driver.

Parameters:
- ROWS, 7, brick rows occupying the top of the playfield.
- COLS, 16, ball-grid columns.
- BRICK_W, 2, ball-grid columns per brick (power of 2); BRICKS_PER_ROW = COLS/BRICK_W.
- TOUGH_ROWS, 2, top rows whose bricks need 2 hits; the other rows need 1.
- BASE_POINTS, 1, points per destroyed brick before the multiplier.
- COMBO_MAX, 7, combo counter saturation value.
- SCORE_W, 10, score width.
- ROW_W, 4, ball row index width.
- COL_W, 4, ball column index width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- hit_valid  in  1  hit request.
- hit_ready  out  1  block idle and able to accept a request.
- ball_row  in  ROW_W  ball row.
- ball_col  in  COL_W  ball column.
- ball_dir  in  2  direction: 00 up-right, 01 up-left, 10 down-right, 11 down-left.
- paddle_touch  in  1  one-cycle pulse; clears the combo.
- load_level  in  1  one-cycle pulse; reloads the field.
- hit_done  out  1  one-cycle response pulse.
- hit_brick  out  1  valid with hit_done: a brick was struck.
- destroyed  out  1  valid with hit_done: the struck brick reached 0 HP.
- bricks  out  ROWS*BRICKS_PER_ROW  alive bitmap; bit r*BRICKS_PER_ROW+c is 1 when HP>0.
- score  out  SCORE_W  total score.
- combo  out  $clog2(COMBO_MAX+1)  current combo count.
- level_clear  out  1  all bricks are dead.

Behaviour:
- Reset (async, active-high) puts the block in this state:
  - HP = 2 for rows < TOUGH_ROWS, else 1, so bricks = all ones.
  - score = 0, combo = 0, level_clear = 0.
  - hit_done, hit_brick and destroyed = 0.
  - FSM in IDLE, hit_ready = 1.
- FSM: IDLE -> P0 -> P1 -> P2 -> APPLY -> IDLE.
  - hit_ready = 1 only in IDLE.
  - The request is accepted on a clock edge where hit_valid && hit_ready; row, col and dir are latched at that edge.
- Probes, one per state; the first live candidate wins and later probes are ignored.
  - P0: own cell (ball_row, ball_col/BRICK_W).
  - P1: vertical neighbour. Row-1 for up directions, row+1 for down directions.
  - P2: horizontal neighbour. Brick index -1 when moving left and ball_col is at the brick's first column; brick index +1 when moving right and ball_col is at the brick's last column.
  - A candidate misses if its row is out of [0,ROWS-1] or its brick column is out of [0,BRICKS_PER_ROW-1]. There is no wrap into an adjacent row.
- Fixed latency: hit_done is high during the APPLY cycle, i.e. the 4th cycle after the accepting edge, for every request, hit or miss.
- APPLY on a hit:
  - Decrement the winning brick's HP.
  - If HP reaches 0: destroyed = 1, score += BASE_POINTS*(combo+1), then combo = min(combo+1, COMBO_MAX).
  - If HP does not reach 0: score and combo are unchanged.
- APPLY on a miss: hit_brick = 0, destroyed = 0, no state change.
- Score saturates at 2^SCORE_W-1 and never wraps.
- Point arithmetic uses SCORE_W+4 bits before the saturation compare.
- paddle_touch sets combo = 0 in any state. When it coincides with APPLY, the points use the pre-clear combo and the final combo is 0.
- level_clear is registered: it is set one cycle after the last HP reaches 0 and is sticky until load_level or reset. While it is set, requests are accepted and always miss.
- load_level in any state restores initial HP, clears combo and level_clear, and returns the FSM to IDLE; score is kept.
  - An in-flight request is aborted: no hit_done is issued.
  - load_level has priority over a simultaneous APPLY.
- Reset mid-operation aborts the request with no hit_done.

Decomposition:
- Package brick_pkg holds:
  - the direction encoding constants;
  - the FSM state enum;
  - HP_TOUGH = 2 and HP_NORMAL = 1;
  - a function giving initial HP from the row index.
- Sub-module brick_probe_addr (combinational): maps (row, col, dir, probe number 0..2) to a brick index plus an in-range flag. It is instantiated once and indexed by the current probe state.

Test Plan:
- Reset, then idle for 10 cycles -> bricks = 56'hFFFFFFFFFFFFFF, score = 0, combo = 0, hit_ready = 1, no hit_done.
- Request row 3, col 5, dir 00 -> hit_done on the 4th cycle with hit_brick = 1, destroyed = 1; bricks[26] = 0, score = 1, combo = 1.
- Row 0, col 0 hit twice, no paddle touch:
  - first hit: destroyed = 0, bricks[0] still 1, score unchanged;
  - second hit: destroyed = 1, bricks[0] = 0, score += combo+1.
- Combo sequence: destroy bricks 40, 41, 42 from combo 0 -> score += 1, 2, 3 (total 6), combo = 3. Then paddle_touch in the same cycle as a 4th destroy -> +4 points and combo = 0.
- Probe fallbacks:
  - brick 35 dead, request row 4, col 6, dir 00 -> P1 hits brick 27;
  - row 0, col 15, dir 00 with brick 7 dead -> P1 is out of range, P2 is out of range (no wrap), hit_brick = 0.
- Boundaries:
  - destroy all 56 bricks -> level_clear = 1 one cycle later; further requests miss;
  - load_level during P1 -> no hit_done, bricks all ones, score retained;
  - score preloaded near 1023 -> saturates at 1023.
